// File: rtl/bright_ramp_ctrl_pkg.sv
// Shared state encoding for the brightness ramp controller.
// No ports; imported by the interface and RTL modules.
package bright_ramp_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RAMP   = 2'd2
  } state_e;

endpackage

// File: rtl/bright_ramp_ctrl_if.sv
// Sample input / smoothed output bundle of bright_ramp_ctrl.
// Ports: I_sample, I_sample_valid in; O_bright_data, O_target, O_busy, O_state out.
interface bright_ramp_ctrl_if
  import bright_ramp_pkg::*;
#(
  parameter int DATA_W = 16
);

  logic [DATA_W-1:0]  I_sample;
  logic               I_sample_valid;
  logic [DATA_W-1:0]  O_bright_data;
  logic [DATA_W-1:0]  O_target;
  logic               O_busy;
  logic [STATE_W-1:0] O_state;

  modport master (
    output I_sample,
    output I_sample_valid,
    input  O_bright_data,
    input  O_target,
    input  O_busy,
    input  O_state
  );

  modport slave (
    input  I_sample,
    input  I_sample_valid,
    output O_bright_data,
    output O_target,
    output O_busy,
    output O_state
  );

endinterface

// File: rtl/bright_ramp_ctrl_ramp_tick_gen.sv
// Reloadable down-counter; stops at zero and flags it.
// Ports: clk_i, rst_i, load_i, load_val_i, en_i in; zero_o out.
module ramp_tick_gen #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bright_ramp_ctrl.sv
// Hysteresis + settle filter feeding a rate-limited brightness ramp.
// Ports: I_clk, I_reset (async, active high); bus (slave side of bright_ramp_ctrl_if).
module bright_ramp_ctrl
  import bright_ramp_pkg::*;
#(
  parameter int          DATA_W        = 16,
  parameter int unsigned THRESH        = 1000,
  parameter int unsigned SETTLE_CYCLES = 50_000_000,
  parameter int unsigned STEP_CYCLES   = 50_000,
  parameter int unsigned STEP          = 16,
  parameter int unsigned INIT          = 2**(DATA_W-1)
) (
  input logic               I_clk,
  input logic               I_reset,
  bright_ramp_ctrl_if.slave bus
);

  localparam int SET_W =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int STP_W =
    (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [SET_W-1:0]  SET_LD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [STP_W-1:0]  STP_LD = STP_W'(STEP_CYCLES - 1);
  localparam logic [DATA_W:0]   THR    = (DATA_W+1)'(THRESH);
  localparam logic [DATA_W-1:0] STP    = DATA_W'(STEP);
  localparam logic [DATA_W-1:0] INI    = DATA_W'(INIT);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic [DATA_W-1:0] cand_q, cand_d;
  logic              done_q, done_d;

  logic              set_load, set_zero;
  logic              step_load, step_zero;

  logic [DATA_W-1:0] s;
  logic              v;
  logic [DATA_W:0]   d_so, d_st;
  logic              sig_out, sig_tgt;
  logic              up;
  logic [DATA_W-1:0] mag, amt, out_step;

  assign s = bus.I_sample;
  assign v = bus.I_sample_valid;

  // Magnitudes one bit wider so nothing wraps.
  assign d_so = (s >= out_q)
    ? {1'b0, s} - {1'b0, out_q}
    : {1'b0, out_q} - {1'b0, s};
  assign d_st = (s >= target_q)
    ? {1'b0, s} - {1'b0, target_q}
    : {1'b0, target_q} - {1'b0, s};

  assign sig_out = d_so > THR;
  assign sig_tgt = d_st > THR;

  // Step size is clamped to the remaining distance: lands exactly.
  assign up       = target_q > out_q;
  assign mag      = up ? target_q - out_q : out_q - target_q;
  assign amt      = (mag < STP) ? mag : STP;
  assign out_step = up ? out_q + amt : out_q - amt;

  ramp_tick_gen #(.W(SET_W)) u_settle (
    .clk_i      (I_clk),
    .rst_i      (I_reset),
    .load_i     (set_load),
    .load_val_i (SET_LD),
    .en_i       (state_q == ST_SETTLE),
    .zero_o     (set_zero)
  );

  ramp_tick_gen #(.W(STP_W)) u_step (
    .clk_i      (I_clk),
    .rst_i      (I_reset),
    .load_i     (step_load),
    .load_val_i (STP_LD),
    .en_i       (state_q == ST_RAMP),
    .zero_o     (step_zero)
  );

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    target_d  = target_q;
    cand_d    = cand_q;
    done_d    = 1'b0;
    set_load  = 1'b0;
    step_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (v && sig_out) begin
          cand_d   = s;
          set_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // Abort has priority over expiry.
        if (v && !sig_out) begin
          state_d = ST_IDLE;
        end else begin
          if (v) begin
            cand_d = s;
          end
          if (set_zero) begin
            target_d  = v ? s : cand_q;
            step_load = 1'b1;
            state_d   = ST_RAMP;
          end
        end
      end
      ST_RAMP: begin
        step_load = step_zero;
        if (step_zero) begin
          out_d = out_step;
        end
        // done_q marks "target reached on the previous step".
        done_d = step_zero && !(v && sig_tgt)
                 && (out_step == target_q);
        if (v && sig_tgt) begin
          target_d = s;
        end else if (done_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q  <= ST_IDLE;
      out_q    <= INI;
      target_q <= INI;
      cand_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      target_q <= target_d;
      cand_q   <= cand_d;
      done_q   <= done_d;
    end
  end

  assign bus.O_bright_data = out_q;
  assign bus.O_target      = target_q;
  assign bus.O_busy        = (state_q != ST_IDLE);
  assign bus.O_state       = state_q;

endmodule

// File: tb/tb_bright_ramp_ctrl.sv
// Self-checking bench for bright_ramp_ctrl.
// Timestamp-based reference model plus directed and random scenarios.
module tb_bright_ramp_ctrl;

  localparam int DW = 12;
  localparam int TH = 100;
  localparam int SC = 8;
  localparam int PC = 4;
  localparam int ST = 16;
  localparam int IN = 2048;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bright_ramp_ctrl_if #(.DATA_W(DW)) bus();

  bright_ramp_ctrl #(
    .DATA_W        (DW),
    .THRESH        (TH),
    .SETTLE_CYCLES (SC),
    .STEP_CYCLES   (PC),
    .STEP          (ST),
    .INIT          (IN)
  ) dut (
    .I_clk   (clk),
    .I_reset (rst),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  // Model: 0 idle, 1 settle, 2 ramp; events kept as absolute edge numbers.
  int m_out, m_tgt, m_cand, m_st, m_deadline, m_next;
  bit m_done;

  wire [26:0] act = {bus.O_bright_data, bus.O_target,
                     bus.O_busy, bus.O_state};

  function automatic logic [26:0] mexp();
    return {12'(m_out), 12'(m_tgt), (m_st != 0), 2'(m_st)};
  endfunction

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_out = IN; m_tgt = IN; m_cand = 0; m_st = 0;
    m_deadline = 0; m_next = 0; m_done = 0;
  endtask

  task automatic model_edge(input bit v, input int s);
    bit ret, was_done;
    int old;
    ncyc++;
    case (m_st)
      0: if (v && absd(s, m_out) > TH) begin
        m_cand = s; m_deadline = ncyc + SC; m_st = 1;
      end
      1: if (v && absd(s, m_out) <= TH) begin
        m_st = 0;
      end else begin
        if (v) m_cand = s;
        if (ncyc == m_deadline) begin
          m_tgt = m_cand; m_next = ncyc + PC; m_st = 2; m_done = 0;
        end
      end
      default: begin
        ret = v && absd(s, m_tgt) > TH;
        was_done = m_done;
        old = m_tgt;
        m_done = 0;
        if (ncyc == m_next) begin
          m_next += PC;
          if (old > m_out) m_out += imin(ST, old - m_out);
          else m_out -= imin(ST, m_out - old);
          m_done = !ret && (m_out == old);
        end
        if (ret) m_tgt = s;
        else if (was_done) m_st = 0;
      end
    endcase
  endtask

  task automatic tick(input bit v, input int s);
    bus.I_sample_valid = v;
    bus.I_sample = 12'(s);
    @(posedge clk);
    model_edge(v, s);
    @(negedge clk);
  endtask

  task automatic assert_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (bus.O_bright_data !== 12'd2048) begin
      bad++; $display("FAIL reset_out got=%0d exp=2048", bus.O_bright_data);
    end
    total++;
    if (bus.O_target !== 12'd2048) begin
      bad++; $display("FAIL reset_tgt got=%0d exp=2048", bus.O_target);
    end
    total++;
    if (bus.O_busy !== 1'b0 || bus.O_state !== 2'd0) begin
      bad++; $display("FAIL reset_st got busy=%0d st=%0d exp 0/0",
                      bus.O_busy, bus.O_state);
    end
    release_reset();
    for (int i = 0; i < 3; i++) begin
      tick(0, 0);
      total++;
      if (act !== mexp()) begin
        bad++; $display("FAIL reset_hold got=%h exp=%h", act, mexp());
      end
    end
  endtask

  task automatic test_sub_threshold();
    for (int i = 0; i < 50; i++) begin
      tick(1, (i % 2 == 0) ? 2100 : int'($urandom_range(1948, 2148)));
      total++;
      if (act !== mexp()) begin
        bad++; $display("FAIL sub_thresh c=%0d got=%h exp=%h",
                        ncyc, act, mexp());
      end
    end
    total++;
    if (bus.O_bright_data !== 12'd2048 || bus.O_state !== 2'd0) begin
      bad++; $display("FAIL sub_thresh_end got out=%0d st=%0d exp 2048/0",
                      bus.O_bright_data, bus.O_state);
    end
  endtask

  task automatic test_step_up();
    int first_tgt = -1, steps = 0, first_val = -1;
    int last_chg = -1, idle_at = -1;
    logic [11:0] prev;
    prev = bus.O_bright_data;
    for (int i = 0; i < 200; i++) begin
      tick(1, 2300);
      total++;
      if (act !== mexp()) begin
        bad++; $display("FAIL step_up c=%0d got=%h exp=%h",
                        ncyc, act, mexp());
      end
      if (first_tgt < 0 && bus.O_target == 12'd2300) first_tgt = i;
      if (bus.O_bright_data != prev) begin
        steps++;
        if (first_val < 0) first_val = int'(bus.O_bright_data);
        last_chg = i;
        prev = bus.O_bright_data;
      end
      if (i > 0 && bus.O_busy === 1'b0) begin
        idle_at = i;
        break;
      end
    end
    total++;
    if (first_tgt != 8) begin
      bad++; $display("FAIL step_up_settle got=%0d exp=8", first_tgt);
    end
    total++;
    if (steps != 16 || first_val != 2064) begin
      bad++; $display("FAIL step_up_steps got n=%0d first=%0d exp 16/2064",
                      steps, first_val);
    end
    total++;
    if (idle_at < 0 || idle_at - last_chg != 1
        || bus.O_bright_data !== 12'd2300) begin
      bad++; $display("FAIL step_up_end got lag=%0d out=%0d exp 1/2300",
                      idle_at - last_chg, bus.O_bright_data);
    end
  endtask

  task automatic test_glitch_abort();
    assert_reset();
    release_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1, (i < 3) ? 2300 : 2050);
      total++;
      if (act !== mexp()) begin
        bad++; $display("FAIL glitch c=%0d got=%h exp=%h",
                        ncyc, act, mexp());
      end
    end
    total++;
    if (bus.O_state !== 2'd0 || bus.O_target !== 12'd2048) begin
      bad++; $display("FAIL glitch_end got st=%0d tgt=%0d exp 0/2048",
                      bus.O_state, bus.O_target);
    end
    for (int i = 0; i < 9; i++) begin
      tick(1, (i < 8) ? 2300 : 2050);
      total++;
      if (act !== mexp()) begin
        bad++; $display("FAIL glitch_exp c=%0d got=%h exp=%h",
                        ncyc, act, mexp());
      end
    end
    total++;
    if (bus.O_state !== 2'd0 || bus.O_target !== 12'd2048
        || bus.O_bright_data !== 12'd2048) begin
      bad++; $display("FAIL abort_wins got st=%0d tgt=%0d exp 0/2048",
                      bus.O_state, bus.O_target);
    end
  endtask

  task automatic test_down_retarget();
    int first = -1, h0 = -1, h1 = -1, h2 = -1;
    logic [11:0] prev;
    for (int i = 0; i < 1200; i++) begin
      tick(1, 40);
      total++;
      if (act !== mexp()) begin
        bad++; $display("FAIL down40 c=%0d got=%h exp=%h",
                        ncyc, act, mexp());
      end
      if (m_st == 0) break;
    end
    total++;
    if (bus.O_bright_data !== 12'd40 || bus.O_busy !== 1'b0) begin
      bad++; $display("FAIL down40_end got=%0d exp=40", bus.O_bright_data);
    end
    for (int i = 0; i < 21; i++) tick(1, 400);
    total++;
    if (bus.O_bright_data !== 12'd88 || bus.O_target !== 12'd400) begin
      bad++; $display("FAIL up400 got out=%0d tgt=%0d exp 88/400",
                      bus.O_bright_data, bus.O_target);
    end
    tick(1, 5);
    total++;
    if (bus.O_target !== 12'd5 || bus.O_bright_data !== 12'd88) begin
      bad++; $display("FAIL retarget got tgt=%0d out=%0d exp 5/88",
                      bus.O_target, bus.O_bright_data);
    end
    prev = bus.O_bright_data;
    for (int j = 0; j < 200; j++) begin
      tick(0, 0);
      total++;
      if (act !== mexp() || bus.O_bright_data > 12'd88) begin
        bad++; $display("FAIL descend c=%0d got=%h exp=%h",
                        ncyc, act, mexp());
      end
      if (bus.O_bright_data != prev) begin
        if (first < 0) first = j;
        h2 = h1; h1 = h0; h0 = int'(bus.O_bright_data);
        prev = bus.O_bright_data;
      end
      if (bus.O_busy === 1'b0) break;
    end
    total++;
    if (first != 2) begin
      bad++; $display("FAIL no_restart got=%0d exp=2", first);
    end
    total++;
    if (h2 != 24 || h1 != 8 || h0 != 5) begin
      bad++; $display("FAIL last_steps got=%0d,%0d,%0d exp 24,8,5",
                      h2, h1, h0);
    end
  endtask

  task automatic test_retarget_equal();
    int k = 0;
    assert_reset();
    release_reset();
    for (int i = 0; i < 21; i++) tick(1, 3000);
    tick(1, 2096);
    total++;
    if (bus.O_target !== 12'd2096 || bus.O_bright_data !== 12'd2096) begin
      bad++; $display("FAIL req_tgt got tgt=%0d out=%0d exp 2096/2096",
                      bus.O_target, bus.O_bright_data);
    end
    for (int j = 0; j < 20; j++) begin
      tick(0, 0);
      k++;
      total++;
      if (act !== mexp()) begin
        bad++; $display("FAIL req c=%0d got=%h exp=%h", ncyc, act, mexp());
      end
      if (bus.O_busy === 1'b0) break;
    end
    total++;
    if (k != 4 || bus.O_bright_data !== 12'd2096) begin
      bad++; $display("FAIL req_idle got k=%0d out=%0d exp 4/2096",
                      k, bus.O_bright_data);
    end
  endtask

  task automatic test_reset_midramp();
    assert_reset();
    release_reset();
    for (int i = 0; i < 17; i++) tick(1, 1000);
    total++;
    if (bus.O_state !== 2'd2 || bus.O_bright_data !== 12'd2016) begin
      bad++; $display("FAIL pre_rst got st=%0d out=%0d exp 2/2016",
                      bus.O_state, bus.O_bright_data);
    end
    assert_reset();
    total++;
    if (bus.O_bright_data !== 12'd2048 || bus.O_state !== 2'd0
        || bus.O_busy !== 1'b0 || bus.O_target !== 12'd2048) begin
      bad++; $display("FAIL async_rst got out=%0d st=%0d exp 2048/0",
                      bus.O_bright_data, bus.O_state);
    end
    release_reset();
    for (int i = 0; i < 30; i++) begin
      tick(0, 0);
      total++;
      if (act !== mexp() || bus.O_bright_data !== 12'd2048) begin
        bad++; $display("FAIL post_rst c=%0d got=%h exp=%h",
                        ncyc, act, mexp());
      end
    end
  endtask

  task automatic test_random();
    int s, r;
    bit v;
    assert_reset();
    release_reset();
    for (int i = 0; i < 4000; i++) begin
      v = ($urandom_range(0, 5) == 0);
      r = int'($urandom_range(0, 7));
      s = int'($urandom_range(0, 4095));
      if (r < 3) s = m_out + int'($urandom_range(0, 300)) - 150;
      if (r == 3) s = 0;
      if (r == 4) s = 4095;
      if (s < 0) s = 0;
      if (s > 4095) s = 4095;
      tick(v, s);
      total++;
      if (act !== mexp()) begin
        bad++; $display("FAIL random c=%0d got=%h exp=%h",
                        ncyc, act, mexp());
      end
    end
  endtask

  initial begin
    bus.I_sample_valid = 1'b0;
    bus.I_sample = '0;
    model_reset();
    test_reset();
    test_sub_threshold();
    test_step_up();
    test_glitch_abort();
    test_down_retarget();
    test_retarget_equal();
    test_reset_midramp();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
